// File: rtl/counter_pkg.sv
// Shared definitions for the sequential-counter library: FSM state encoding
// and the default counter width.
package counter_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/prescale_tick.sv
// Prescaler: emits a one-cycle tick on every PRESCALE-th enabled cycle.
// clr restarts the phase from zero and suppresses a tick in that cycle.
// With PRESCALE=1 the tick simply follows en.
module prescale_tick
    import counter_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    // A one-bit counter is kept even for PRESCALE=1 so the ports stay uniform.
    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next phase: clear on clr, advance and wrap only on enabled cycles.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = ZERO;
        end else if (en) begin
            if (cnt_q == LAST) begin
                cnt_d = ZERO;
            end else begin
                cnt_d = cnt_q + ONE;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Phase register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= ZERO;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = en & ~clr & (cnt_q == LAST);

endmodule

// File: rtl/down_counter_tc.sv
// Loadable down-counter / countdown timer with registered terminal-count
// pulse, one-shot or auto-reload operation, and a prescaled step rate.
module down_counter_tc
    import counter_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             busy,
    output logic             zero
);

    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] reload_q;
    logic [WIDTH-1:0] reload_d;
    logic             tc_q;
    logic             tc_d;
    logic             run_en_s;
    logic             tick_s;

    // The prescaler only advances while actually counting, so its phase is
    // frozen by en=0 and meaningless outside RUN (load always restarts it).
    assign run_en_s = en & (state_q == ST_RUN);

    prescale_tick #(
        .PRESCALE(PRESCALE)
    ) u_prescale (
        .clk (clk),
        .rst (rst),
        .en  (run_en_s),
        .clr (load),
        .tick(tick_s)
    );

    // Next-state logic: load has priority, then prescaled steps in RUN.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        tc_d     = 1'b0;
        if (load) begin
            count_d  = load_val;
            reload_d = load_val;
            state_d  = (load_val != ZERO) ? ST_RUN : ST_IDLE;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (tick_s) begin
                        if (count_q > ONE) begin
                            count_d = count_q - ONE;
                        end else begin
                            // Terminal step: never decrement past zero.
                            tc_d = 1'b1;
                            if (auto_reload) begin
                                count_d = reload_q;
                            end else begin
                                count_d = ZERO;
                                state_d = ST_DONE;
                            end
                        end
                    end else begin
                        count_d = count_q;
                    end
                end
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    // Unused encoding: park safely at zero in IDLE.
                    state_d = ST_IDLE;
                    count_d = ZERO;
                end
            endcase
        end
    end

    // State, count, reload and terminal-count registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            count_q  <= ZERO;
            reload_q <= ZERO;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
        end
    end

    assign out  = count_q;
    assign tc   = tc_q;
    assign busy = (state_q == ST_RUN);
    assign zero = (count_q == ZERO);

endmodule

// File: tb/tb_down_counter_tc.sv
// Scoreboard bench: two DUT instances (PRESCALE=1 and PRESCALE=3) share the
// same stimulus; a rule-level timer model predicts each one per clock edge.
module tb_down_counter_tc;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         load;
    logic [W-1:0] load_val;
    logic         auto_reload;
    logic [W-1:0] out0, out1;
    logic         tc0, tc1, busy0, busy1, zero0, zero1;

    always #5 clk = ~clk;

    down_counter_tc #(.WIDTH(W), .PRESCALE(1)) dut0 (
        .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
        .auto_reload(auto_reload), .out(out0), .tc(tc0), .busy(busy0), .zero(zero0)
    );

    down_counter_tc #(.WIDTH(W), .PRESCALE(3)) dut1 (
        .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
        .auto_reload(auto_reload), .out(out1), .tc(tc1), .busy(busy1), .zero(zero1)
    );

    typedef struct packed {
        logic [W-1:0] out;
        logic         tc;
        logic         busy;
        logic         zero;
    } obs_t;

    obs_t q0[$];
    obs_t q1[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Timer model: remaining count, reload value, mode (0 idle, 1 run,
    // 2 done), enabled cycles since load modulo prescale, and tc flag.
    int m_cnt [2];
    int m_rel [2];
    int m_mode[2];
    int m_ph  [2];
    bit m_tc  [2];
    int pre   [2] = '{1, 3};

    function automatic obs_t predicted(int k);
        obs_t e;
        e.out  = m_cnt[k][W-1:0];
        e.tc   = m_tc[k];
        e.busy = (m_mode[k] == 1);
        e.zero = (m_cnt[k] == 0);
        return e;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0; m_rel[k] = 0; m_mode[k] = 0; m_ph[k] = 0; m_tc[k] = 1'b0;
        end
    endfunction

    // Advance the model across one rising edge using the applied inputs.
    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_cnt[k] = 0; m_rel[k] = 0; m_mode[k] = 0; m_ph[k] = 0; m_tc[k] = 1'b0;
            end else begin
                m_tc[k] = 1'b0;
                if (load) begin
                    m_cnt[k]  = int'(load_val);
                    m_rel[k]  = int'(load_val);
                    m_ph[k]   = 0;
                    m_mode[k] = (load_val != 0) ? 1 : 0;
                end else if (m_mode[k] == 1 && en) begin
                    m_ph[k] = m_ph[k] + 1;
                    if (m_ph[k] == pre[k]) begin
                        m_ph[k] = 0;
                        if (m_cnt[k] > 1) begin
                            m_cnt[k] = m_cnt[k] - 1;
                        end else begin
                            m_tc[k] = 1'b1;
                            if (auto_reload) begin
                                m_cnt[k] = m_rel[k];
                            end else begin
                                m_cnt[k]  = 0;
                                m_mode[k] = 2;
                            end
                        end
                    end
                end
            end
        end
        q0.push_back(predicted(0));
        q1.push_back(predicted(1));
    endtask

    task automatic compare(string name, obs_t act, obs_t exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s t=%0t: got out=%0d tc=%b busy=%b zero=%b, expected out=%0d tc=%b busy=%b zero=%b",
                     name, $time, act.out, act.tc, act.busy, act.zero,
                     exp.out, exp.tc, exp.busy, exp.zero);
        end
    endtask

    // Monitor: every settled cycle presents an output; pop and compare.
    always @(negedge clk) begin
        if (q0.size() > 0) compare("p1", {out0, tc0, busy0, zero0}, q0.pop_front());
        if (q1.size() > 0) compare("p3", {out1, tc1, busy1, zero1}, q1.pop_front());
    end

    // One clock of stimulus; inputs change 2ns after the rising edge.
    task automatic step(input logic ld, input logic [W-1:0] lv, input logic e, input logic ar);
        load = ld; load_val = lv; en = e; auto_reload = ar;
        @(posedge clk);
        model_edge();
        #2;
    endtask

    // Reset asserted between edges: outputs must clear before the next edge.
    task automatic mid_reset();
        @(negedge clk);
        #1;
        load = 1'b0; en = 1'b1;
        rst = 1'b1;
        model_reset();
        #1;
        compare("rst_async_p1", {out0, tc0, busy0, zero0}, predicted(0));
        compare("rst_async_p3", {out1, tc1, busy1, zero1}, predicted(1));
        @(posedge clk);
        model_edge();
        #2;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; load = 1'b0; load_val = '0; auto_reload = 1'b0;
        model_reset();
        #20;
        compare("reset_p1", {out0, tc0, busy0, zero0}, predicted(0));
        compare("reset_p3", {out1, tc1, busy1, zero1}, predicted(1));
        rst = 1'b0;
        step(1'b0, 4'd0, 1'b1, 1'b0);

        // One-shot from 5, then hold at 0.
        step(1'b1, 4'd5, 1'b1, 1'b0);
        for (int i = 0; i < 25; i++) step(1'b0, 4'd0, 1'b1, 1'b0);

        // Auto-reload from 3.
        step(1'b1, 4'd3, 1'b1, 1'b1);
        for (int i = 0; i < 24; i++) step(1'b0, 4'd0, 1'b1, 1'b1);

        // Prescaled count with enable dropped mid-period.
        step(1'b1, 4'd2, 1'b1, 1'b0);
        step(1'b0, 4'd0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 4'd0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 4'd0, 1'b1, 1'b0);

        // Load beats a terminal step, then a zero load parks in IDLE.
        step(1'b1, 4'd1, 1'b1, 1'b0);
        step(1'b1, 4'd9, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 4'd0, 1'b1, 1'b0);
        step(1'b1, 4'd0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 4'd0, 1'b1, 1'b1);

        // Full-scale one-shot: no wrap after reaching 0.
        step(1'b1, 4'd15, 1'b1, 1'b0);
        for (int i = 0; i < 55; i++) step(1'b0, 4'd0, 1'b1, 1'b0);

        // Reset while the PRESCALE=1 counter shows 5.
        step(1'b1, 4'd8, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 4'd0, 1'b1, 1'b0);
        mid_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 4'd0, 1'b1, 1'b0);

        // Randomized traffic, short reloads favoured to exercise tc often.
        for (int i = 0; i < 800; i++) begin
            logic         ld;
            logic [W-1:0] lv;
            ld = ($urandom_range(0, 11) == 0);
            lv = ($urandom_range(0, 1) == 1) ? W'($urandom_range(0, 3)) : W'($urandom_range(0, 15));
            if ($urandom_range(0, 150) == 0) begin
                mid_reset();
            end else begin
                step(ld, lv, ($urandom_range(0, 4) != 0), $urandom_range(0, 1) == 1);
            end
        end

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/down_counter_tc.md
Name: down_counter_tc

Overview:
Loadable down-counter/countdown timer. It is the decrementing counterpart of the team's 4-bit up counter. Software or a controller loads a start value. The block counts down to zero on enabled prescaled ticks and raises a one-cycle terminal-count pulse. It then either stops (one-shot) or reloads and continues (auto-reload). It sits beside the up counter in the sequential-circuits library and serves as the timeout/interval source for downstream FSMs.

Parameters:
WIDTH, 4, counter and load value width in bits
PRESCALE, 1, number of enabled clk cycles per count step (minimum 1)

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  reset, asynchronous and active-high; clears all state immediately
en  input  1  count enable; low freezes counter and prescaler
load  input  1  synchronous load strobe
load_val  input  WIDTH  start/reload value, sampled when load=1
auto_reload  input  1  1: reload on terminal count; 0: one-shot stop
out  output  WIDTH  current count
tc  output  1  one-cycle terminal-count pulse, registered
busy  output  1  high while in RUN state
zero  output  1  high when out==0

Behaviour:
- Reset (async assert, any time): out=0, tc=0, busy=0, zero=1, state=IDLE, reload_reg=0, prescaler count=0. After reset is released, the first rising edge acts normally.
- FSM states:
  - IDLE: reset state; no counting.
  - RUN: counting.
  - DONE: one-shot finished, holding 0.
- load=1 (any state, highest priority, en ignored):
  - out<=load_val, reload_reg<=load_val, prescaler cleared, tc<=0.
  - load_val!=0 -> RUN; load_val==0 -> IDLE.
  - Load latency: out shows load_val after the loading edge.
- Step condition: state==RUN, en=1, load=0, and prescaler tick.
  - The tick fires on every PRESCALE-th enabled cycle counted from the load.
  - With PRESCALE=1, every enabled cycle is a step.
- On a step with out>1: out<=out-1, tc<=0.
- On a step with out==1 and auto_reload=0: out<=0, tc<=1, state->DONE.
- On a step with out==1 and auto_reload=1: out<=reload_reg, tc<=1, state stays RUN. out never shows 0 in this case.
- tc is asserted in the same cycle the new out value (0 or reload) is visible. It is high for exactly one clk and cleared on the next edge unless another terminal step occurs. With reload_reg==1 and PRESCALE=1, tc stays high on consecutive cycles.
- auto_reload is sampled at the terminal step, not at load.
- en=0: out, state and prescaler count all hold; tc<=0.
- In IDLE or DONE, out holds and en has no effect. Only load leaves these states.
- No underflow: out never decrements below 0. No wrap to 2^WIDTH-1 under any input.
- busy=(state==RUN); zero=(out==0), combinational from registers.
- Reset asserted mid-count aborts immediately. No tc is generated for an aborted count.

Decomposition:
- Shared package (counter_pkg): state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2, plus default WIDTH.
- One sub-module: prescale_tick (param PRESCALE; ports clk, rst, en, clr, tick).
  - tick=1 on the enabled cycle where the internal count hits PRESCALE-1; the count then wraps to 0.
  - clr (driven by load) zeroes the count.
  - PRESCALE=1 makes tick=en.
- down_counter_tc contains the FSM, count register, reload register and tc register.

Test Plan:
All scenarios use WIDTH=4, PRESCALE=1 unless noted.
- Reset: rst=1 at t=0, release at 20ns -> out=0, tc=0, busy=0, zero=1. Assert rst mid-count at out=5 -> out=0 immediately, before the next edge; no tc.
- One-shot: load_val=5, auto_reload=0, en=1 -> out 5,4,3,2,1,0 on successive edges; tc high one cycle together with out=0; busy falls; out holds 0 for 10 more cycles.
- Auto-reload: load_val=3, auto_reload=1 -> out 3,2,1,3,2,1,...; tc pulses every 3rd cycle coincident with out=3; out never 0; busy stays 1.
- Enable gating plus prescaler (PRESCALE=3): load 2, en=1 -> out steps every 3 cycles. Drop en for 4 cycles mid-period -> out and phase frozen; the step resumes after the remaining cycles.
- Load priority: load_val=9 asserted on the same edge as a terminal step from out=1 -> out=9, tc=0, state RUN. Then load_val=0 -> out=0, IDLE, busy=0, no tc.
- Max value: load 15 in one-shot -> exactly 15 steps to 0, single tc, no wrap to 15.
